mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 2:1 select datapath.
- Two requesters (A, B) compete for one downstream output; the block grants one at a time, drives the select and moves data through a single registered output stage.
- Uses a valid/ready handshake on the output.
- Each grant lasts until the end of a burst, a request drop, or a beat limit.

---
 rtl/mux_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux_rr_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-requester round-robin arbiter feeding a
// single registered valid/ready output stage through a 2:1 select.
module mux_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              a_req_in,
  input  logic [DATA_W-1:0] a_data_in,
  input  logic              a_last_in,
  output logic              a_gnt_out,
  input  logic              b_req_in,
  input  logic [DATA_W-1:0] b_data_in,
  input  logic              b_last_in,
  output logic              b_gnt_out,
  output logic              y_valid_out,
  output logic [DATA_W-1:0] y_data_out,
  input  logic              y_ready_in,
  output logic              sel_out,
  output logic              busy_out
);

  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;
  logic              sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              yv_q, yv_d;
  logic [DATA_W-1:0] yd_q, yd_d;

  logic              stage_free;
  logic              cur_req;
  logic              cur_last;
  logic              cur_gnt;
  logic              accept;
  logic              at_max;
  logic [DATA_W-1:0] cur_data;

  assign stage_free = !yv_q || y_ready_in;

  // Grants are suppressed during reset so no beat slips in.
  assign a_gnt_out = rst_n_in && (state_q == GRANT_A) && stage_free;
  assign b_gnt_out = rst_n_in && (state_q == GRANT_B) && stage_free;

  // While granted, sel_q always names the owner.
  assign cur_req  = sel_q ? b_req_in  : a_req_in;
  assign cur_last = sel_q ? b_last_in : a_last_in;
  assign cur_data = sel_q ? b_data_in : a_data_in;
  assign cur_gnt  = a_gnt_out || b_gnt_out;
  assign accept   = cur_req && cur_gnt;
  assign at_max   = (cnt_q + CW'(1)) == CW'(MAX_BURST);

  assign y_valid_out = yv_q;
  assign y_data_out  = yd_q;
  assign sel_out     = sel_q;
  assign busy_out    = (state_q != IDLE);

  // Arbitration, burst tracking and output-stage next state.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    yv_d    = yv_q;
    yd_d    = yd_q;

    unique case (state_q)
      IDLE: begin
        if (a_req_in && (!b_req_in || last_q)) begin
          state_d = GRANT_A;
          sel_d   = 1'b0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (b_req_in) begin
          state_d = GRANT_B;
          sel_d   = 1'b1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT_A, GRANT_B: begin
        if (accept) begin
          cnt_d = cnt_q + CW'(1);
          if (cur_last || at_max) state_d = IDLE;
        end else if (cur_gnt) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      yd_d = cur_data;
      yv_d = 1'b1;
    end else if (yv_q && y_ready_in) begin
      yv_d = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      sel_q   <= 1'b0;
      cnt_q   <= '0;
      yv_q    <= 1'b0;
      yd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      yv_q    <= yv_d;
      yd_q    <= yd_d;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: random and directed stimulus, transaction-level
// reference model and a data scoreboard drained by a separate monitor.
module tb_mux_rr_arbiter;

  localparam int DW = 8;
  localparam int MB = 16;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          a_req_in = 1'b0, b_req_in = 1'b0;
  logic [DW-1:0] a_data_in = '0, b_data_in = '0;
  logic          a_last_in = 1'b0, b_last_in = 1'b0;
  logic          a_gnt_out, b_gnt_out;
  logic          y_valid_out;
  logic [DW-1:0] y_data_out;
  logic          y_ready_in = 1'b1;
  logic          sel_out, busy_out;

  always #5 clk_in = ~clk_in;

  mux_rr_arbiter #(.DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .a_req_in(a_req_in), .a_data_in(a_data_in),
    .a_last_in(a_last_in), .a_gnt_out(a_gnt_out),
    .b_req_in(b_req_in), .b_data_in(b_data_in),
    .b_last_in(b_last_in), .b_gnt_out(b_gnt_out),
    .y_valid_out(y_valid_out), .y_data_out(y_data_out),
    .y_ready_in(y_ready_in), .sel_out(sel_out),
    .busy_out(busy_out)
  );

  int checks = 0;
  int fails  = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW:0]   a_seq[$], b_seq[$];
  int pa = 0, pb = 0, plast = 30, prdy = 100;
  bit acc_a = 0, acc_b = 0, from_a = 0, from_b = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: owner -1 = nobody, 0 = A, 1 = B.
  bit            m_on = 0;
  int            owner = -1, served = 1, msel = 0, beats = 0;
  bit            myv = 0;
  logic [DW-1:0] myd = '0;

  always @(negedge clk_in) begin : model
    bit free, ea, eb, g, r, l;
    logic [DW-1:0] d;
    int nxt;
    free = !myv || y_ready_in;
    ea = rst_n_in && owner == 0 && free;
    eb = rst_n_in && owner == 1 && free;
    if (m_on) begin
      chk("a_gnt", a_gnt_out, ea);
      chk("b_gnt", b_gnt_out, eb);
      chk("y_valid", y_valid_out, myv);
      chk("y_data", y_data_out, myd);
      chk("sel", sel_out, msel);
      chk("busy", busy_out, owner != -1);
    end
    if (!rst_n_in) begin
      m_on = 1; owner = -1; served = 1; msel = 0;
      beats = 0; myv = 0; myd = '0;
      exp_q.delete();
    end else if (m_on) begin
      if (owner < 0) begin
        if (myv && y_ready_in) myv = 0;
        if (a_req_in && b_req_in) nxt = 1 - served;
        else if (a_req_in)        nxt = 0;
        else if (b_req_in)        nxt = 1;
        else                      nxt = -1;
        if (nxt >= 0) begin
          owner = nxt; served = nxt; msel = nxt; beats = 0;
        end
      end else begin
        g = (owner == 0) ? ea : eb;
        r = (owner == 0) ? a_req_in : b_req_in;
        l = (owner == 0) ? a_last_in : b_last_in;
        d = (owner == 0) ? a_data_in : b_data_in;
        if (g && r) begin
          exp_q.push_back(d);
          myd = d; myv = 1; beats++;
          if (l || beats == MB) owner = -1;
        end else begin
          if (myv && y_ready_in) myv = 0;
          if (g) owner = -1;
        end
      end
    end
  end

  // Monitor: every beat leaving y must be the oldest expected one.
  always @(negedge clk_in) begin
    if (m_on && rst_n_in && y_valid_out && y_ready_in) begin
      if (exp_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL y_drain: got %0h expected none at %0t",
                 y_data_out, $time);
      end else begin
        chk("y_drain", y_data_out, exp_q.pop_front());
      end
    end
  end

  // Acceptance seen by the sources, used only to advance sequences.
  always @(negedge clk_in) begin
    acc_a = rst_n_in && a_req_in && a_gnt_out;
    acc_b = rst_n_in && b_req_in && b_gnt_out;
  end

  task automatic drive();
    from_a = a_seq.size() != 0;
    from_b = b_seq.size() != 0;
    if (from_a) {a_last_in, a_data_in} = a_seq[0];
    else begin
      a_data_in = DW'($urandom);
      a_last_in = $urandom_range(99) < plast;
    end
    if (from_b) {b_last_in, b_data_in} = b_seq[0];
    else begin
      b_data_in = DW'($urandom);
      b_last_in = $urandom_range(99) < plast;
    end
    a_req_in   = from_a || ($urandom_range(99) < pa);
    b_req_in   = from_b || ($urandom_range(99) < pb);
    y_ready_in = $urandom_range(99) < prdy;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in); #1;
      if (acc_a && from_a) void'(a_seq.pop_front());
      if (acc_b && from_b) void'(b_seq.pop_front());
      drive();
    end
  endtask

  initial begin
    rst_n_in = 1'b0; pa = 100; pb = 100; prdy = 100;
    run(3);
    rst_n_in = 1'b1;
    run(4);
    pa = 0; pb = 0;
    run(6);

    a_seq = '{9'h011, 9'h022, 9'h133};
    run(10);

    for (int k = 0; k < 4; k++) begin
      a_seq.push_back({1'b0, 8'(8'hA0 + 2 * k)});
      a_seq.push_back({1'b1, 8'(8'hA1 + 2 * k)});
      b_seq.push_back({1'b0, 8'(8'hB0 + 2 * k)});
      b_seq.push_back({1'b1, 8'(8'hB1 + 2 * k)});
    end
    run(40);

    for (int k = 0; k < 20; k++) a_seq.push_back({1'b0, 8'(k)});
    for (int k = 0; k < 3; k++) b_seq.push_back({1'b0, 8'(8'hC0 + k)});
    run(50);

    b_seq = '{9'h0AA, 9'h1BB};
    run(3);
    prdy = 0;
    run(3);
    prdy = 100;
    run(5);

    for (int k = 0; k < 10; k++) a_seq.push_back({1'b0, 8'(8'h50 + k)});
    prdy = 70;
    run(5);
    rst_n_in = 1'b0;
    run(1);
    rst_n_in = 1'b1;
    a_seq.delete();
    run(5);

    for (int r = 0; r < 8; r++) begin
      pa    = $urandom_range(30, 100);
      pb    = $urandom_range(30, 100);
      plast = (r == 2) ? 0 : $urandom_range(0, 50);
      prdy  = (r == 2) ? 100 : $urandom_range(20, 100);
      if (r == 2) begin pa = 100; pb = 100; end
      run(300);
      if (r == 5) begin
        rst_n_in = 1'b0;
        run(1);
        rst_n_in = 1'b1;
      end
    end

    pa = 0; pb = 0; prdy = 100;
    a_seq.delete(); b_seq.delete();
    run(8);
    chk("queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
